// File: rtl/digilock_ctrl.sv
// rtl/digilock_ctrl.sv - DigiLock sequencing controller
//
// Captures 4-digit BCD codes, keeps the stored password on cmp_a and the
// latest attempt on cmp_b for the external 16-bit equality comparator, and
// turns its cmp_f result into lock/alarm plus a consecutive-failure count.
//
// Ports:
//   clock          in   1   system clock, rising edge
//   reset          in   1   asynchronous, active-low
//   enter          in   1   submit key (level, one action per rising transition)
//   operacao       in   1   OPEN only: 0 = relock, 1 = program new password
//   digitos_valor  in   16  4 BCD digits, [15:12] most significant
//   cmp_f          in   1   comparator result (cmp_a == cmp_b)
//   cmp_a          out  16  stored password
//   cmp_b          out  16  last captured attempt
//   lock           out  1   door locked
//   alarm          out  1   alarm latched
//   busy           out  1   comparison in flight
//   fails          out  2   consecutive failed attempts
module digilock_ctrl #(
  parameter int MAX_ATTEMPTS = 3
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        enter,
  input  logic        operacao,
  input  logic [15:0] digitos_valor,
  input  logic        cmp_f,
  output logic [15:0] cmp_a,
  output logic [15:0] cmp_b,
  output logic        lock,
  output logic        alarm,
  output logic        busy,
  output logic [1:0]  fails
);

  typedef enum logic [2:0] {
    SETUP  = 3'd0,
    LOCKED = 3'd1,
    CMP    = 3'd2,
    OPEN   = 3'd3,
    ALARM  = 3'd4
  } state_t;

  localparam logic [2:0] MAX_W = 3'(MAX_ATTEMPTS);

  state_t     state;
  logic       enter_q;
  logic       ent;
  logic       code_ok;
  logic [2:0] fails_inc;

  assign ent       = enter & ~enter_q;
  assign code_ok   = (digitos_valor[15:12] <= 4'd9) && (digitos_valor[11:8] <= 4'd9) &&
                     (digitos_valor[7:4]   <= 4'd9) && (digitos_valor[3:0]  <= 4'd9);
  assign fails_inc = {1'b0, fails} + 3'd1;

  // lock/alarm/busy are registers updated together with the state so they
  // never depend combinationally on inputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state   <= SETUP;
      enter_q <= 1'b0;
      cmp_a   <= 16'h0000;
      cmp_b   <= 16'h0000;
      lock    <= 1'b0;
      alarm   <= 1'b0;
      busy    <= 1'b0;
      fails   <= 2'd0;
    end else begin
      enter_q <= enter;
      case (state)
        SETUP: begin
          if (ent && code_ok) begin
            cmp_a <= digitos_valor;
            state <= LOCKED;
            lock  <= 1'b1;
          end
        end
        LOCKED: begin
          if (ent && code_ok) begin
            cmp_b <= digitos_valor;
            state <= CMP;
            busy  <= 1'b1;
          end
        end
        CMP: begin
          busy <= 1'b0;
          if (cmp_f) begin
            fails <= 2'd0;
            state <= OPEN;
            lock  <= 1'b0;
          end else if (fails_inc == MAX_W) begin
            fails <= fails_inc[1:0];
            state <= ALARM;
            alarm <= 1'b1;
          end else begin
            fails <= fails_inc[1:0];
            state <= LOCKED;
          end
        end
        OPEN: begin
          // Relock ignores the digits entirely; only reprogramming needs a valid code.
          if (ent && !operacao) begin
            state <= LOCKED;
            lock  <= 1'b1;
          end else if (ent && operacao && code_ok) begin
            cmp_a <= digitos_valor;
            state <= LOCKED;
            lock  <= 1'b1;
          end
        end
        ALARM: begin
          // Absorbing until reset.
        end
        default: begin
          state <= SETUP;
          lock  <= 1'b0;
          alarm <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
